// File: rtl/vga_pat_sched_pkg.sv
// vga_pat_sched_pkg: register map, bit indices, FSM encoding and step helper
package vga_pat_sched_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PAT    = 2'd1;
  localparam logic [1:0] REG_DWELL  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int CTRL_AUTO_EN = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIR     = 2;
  localparam int ST_PEND      = 0;
  localparam int ST_IRQF      = 1;
  localparam int ST_ERR       = 2;
  localparam int ST_FRAME_LSB = 8;
  typedef enum logic [1:0] {S_MANUAL = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_e;
  function automatic int unsigned pat_step(input int unsigned p, input logic dec, input int unsigned n);
    return dec ? ((p == 0) ? n - 1 : p - 1) : ((p >= n - 1) ? 0 : p + 1);
  endfunction
endpackage

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: vsync_n falling-edge detector and 8-bit wrapping frame counter
module vga_frame_tick (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_n,
  output logic       tick,
  output logic [7:0] frame_cnt
);
  logic       vsync_d_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  assign tick      = vsync_d_q & ~vsync_n;
  assign frame_cnt = frame_cnt_q;
  // count every frame boundary, wrapping naturally at 255
  always_comb frame_cnt_d = frame_cnt_q + {7'd0, tick};
  // vsync delay starts low so a low vsync at reset release gives no false tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vsync_d_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      vsync_d_q   <= vsync_n;
      frame_cnt_q <= frame_cnt_d;
    end
endmodule

// File: rtl/vga_pat_sched.sv
// vga_pat_sched: frame-synchronous pattern-id scheduler; define VGA_PAT_SCHED_IRQ_EN to build the irq logic
module vga_pat_sched #(
  parameter int PAT_W     = 2,
  parameter int NUM_PAT   = 4,
  parameter int DWELL_W   = 16,
  parameter int DWELL_RST = 60
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             vsync_n,
  input  logic             key_pulse,
  output logic [PAT_W-1:0] pat_id,
  output logic             irq
);
  import vga_pat_sched_pkg::*;
`ifdef VGA_PAT_SCHED_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b101;
`endif
  state_e             state_q, state_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d, dwell_last;
  logic [PAT_W-1:0]   pat_q, pat_d, tgt_q, tgt_d, tgt_eff, step_pat;
  logic               pend_q, pend_d, key_q, key_d, err_q, err_d;
  logic               tick, bus_wr, pat_wr, st_wr, pat_ok, manual, run;
  logic               cpu_go, key_go, auto_go, irqf;
  logic [7:0]         frame_cnt;
  vga_frame_tick u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .vsync_n   (vsync_n),
    .tick      (tick),
    .frame_cnt (frame_cnt)
  );
  assign bus_wr     = chipselect & ~write_n;
  assign pat_wr     = bus_wr & (address == REG_PAT);
  assign st_wr      = bus_wr & (address == REG_STATUS);
  assign pat_ok     = writedata < 32'(NUM_PAT);
  assign manual     = state_q == S_MANUAL;
  assign run        = (state_q == S_RUN) & ctrl_q[CTRL_AUTO_EN];
  assign tgt_eff    = (pat_wr & pat_ok) ? writedata[PAT_W-1:0] : tgt_q;
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
  assign step_pat   = PAT_W'(pat_step(32'(pat_q), ctrl_q[CTRL_DIR], NUM_PAT));
  assign cpu_go     = tick & (pend_q | (pat_wr & pat_ok));
  assign key_go     = tick & manual & (key_q | key_pulse);
  assign auto_go    = tick & run & (cnt_q >= dwell_last);
  assign pat_id     = pat_q;
  // next-state: register writes, tick arbitration CPU > key > auto, mode and pause control
  always_comb begin
    ctrl_d  = (bus_wr & (address == REG_CTRL)) ? (writedata[2:0] & CTRL_MASK) : ctrl_q;
    dwell_d = (bus_wr & (address == REG_DWELL)) ? writedata[DWELL_W-1:0] : dwell_q;
    tgt_d   = tgt_eff;
    pend_d  = cpu_go ? 1'b0 : (pend_q | (pat_wr & pat_ok));
    key_d   = (tick | ~manual) ? 1'b0 : (key_q | key_pulse);
    pat_d   = cpu_go ? tgt_eff : (key_go | auto_go) ? step_pat : pat_q;
    cnt_d   = (~ctrl_q[CTRL_AUTO_EN] | cpu_go | auto_go) ? '0 : (tick & run) ? cnt_q + 1'b1 : cnt_q;
    state_d = ~ctrl_q[CTRL_AUTO_EN] ? S_MANUAL : manual ? S_RUN :
              key_pulse ? ((state_q == S_RUN) ? S_PAUSE : S_RUN) : state_q;
    err_d   = (pat_wr & ~pat_ok) | (err_q & ~(st_wr & writedata[ST_ERR]));
  end
  // scheduler state registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_MANUAL;
      ctrl_q  <= 3'd0;
      dwell_q <= DWELL_W'(DWELL_RST);
      cnt_q   <= '0;
      pat_q   <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      key_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
`ifdef VGA_PAT_SCHED_IRQ_EN
  logic irqf_q, irqf_d;
  // flag any tick that changes pat_id; a same-cycle set beats the W1C clear
  always_comb irqf_d = (tick & (pat_d != pat_q)) | (irqf_q & ~(st_wr & writedata[ST_IRQF]));
  // interrupt flag register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irqf_q <= 1'b0;
    else irqf_q <= irqf_d;
  assign irqf = irqf_q;
  assign irq  = irqf_q & ctrl_q[CTRL_IRQ_EN];
`else
  assign irqf = 1'b0;
  assign irq  = 1'b0;
`endif
  // combinational register read mux
  always_comb
    readdata = (address == REG_CTRL)  ? {29'd0, ctrl_q} :
               (address == REG_PAT)   ? 32'(pat_q) :
               (address == REG_DWELL) ? 32'(dwell_q) :
               {16'd0, frame_cnt, 5'd0, err_q, irqf, pend_q};
endmodule

// File: tb/tb_vga_pat_sched.sv
// tb_vga_pat_sched: scoreboard bench with a frame-level reference model
module tb_vga_pat_sched;
  localparam int NUM_PAT = 4;
`ifdef VGA_PAT_SCHED_IRQ_EN
  localparam int IRQ_BUILT = 1;
`else
  localparam int IRQ_BUILT = 0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = 32'd0, readdata;
  logic        vsync_n = 1'b1, key_pulse = 1'b0, irq;
  logic [1:0]  pat_id;
  always #5 clk = ~clk;
  vga_pat_sched dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .vsync_n(vsync_n), .key_pulse(key_pulse), .pat_id(pat_id), .irq(irq)
  );
  typedef struct { logic [1:0] a; logic [31:0] d; logic i; } rd_t;
  rd_t  rd_q[$];
  int   pat_q[$];
  int   errors = 0, checks = 0;
  logic rd_stb = 1'b0, mon_en = 1'b0;
  int   last_pat = 0, mon_e;
  rd_t  mon_r;
  // reference model: mode 0 manual, 1 run, 2 pause
  int m_pat, m_ctrl, m_dwell, m_cnt, m_frames, m_tgt, m_mode;
  bit m_pend, m_key, m_err, m_irqf;
  function automatic void m_reset();
    if (m_pat != 0) pat_q.push_back(0);
    m_pat = 0; m_ctrl = 0; m_dwell = 60; m_cnt = 0; m_frames = 0; m_tgt = 0; m_mode = 0;
    m_pend = 0; m_key = 0; m_err = 0; m_irqf = 0;
  endfunction
  function automatic int nxt();
    return (m_pat + (((m_ctrl & 4) != 0) ? NUM_PAT - 1 : 1)) % NUM_PAT;
  endfunction
  function automatic void m_write(input int a, input int unsigned d);
    case (a)
      0: begin
        m_ctrl = int'(d & (IRQ_BUILT != 0 ? 7 : 5));
        if ((m_ctrl & 1) == 0) begin m_mode = 0; m_cnt = 0; end
        else if (m_mode == 0) begin m_mode = 1; m_key = 0; end
      end
      1: if (d < NUM_PAT) begin m_pend = 1; m_tgt = int'(d); end else m_err = 1;
      2: m_dwell = int'(d & 32'hffff);
      default: begin if ((d & 2) != 0) m_irqf = 0; if ((d & 4) != 0) m_err = 0; end
    endcase
  endfunction
  function automatic int m_read(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_pat;
      2: return m_dwell;
      default: return (m_frames << 8) | (int'(m_err) << 2) | (int'(m_irqf) << 1) | int'(m_pend);
    endcase
  endfunction
  function automatic void m_tick();
    int old = m_pat;
    m_frames = (m_frames + 1) % 256;
    if (m_pend) begin m_pat = m_tgt; m_pend = 0; m_cnt = 0; end
    else if (m_mode == 0 && m_key) m_pat = nxt();
    else if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt >= ((m_dwell == 0) ? 1 : m_dwell)) begin m_pat = nxt(); m_cnt = 0; end
    end
    m_key = 0;
    if (m_pat != old) begin pat_q.push_back(m_pat); if (IRQ_BUILT != 0) m_irqf = 1; end
  endfunction
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    m_write(int'(a), d);
    cyc();
  endtask
  task automatic rd(input logic [1:0] a);
    rd_t e;
    e.a = a;
    e.d = 32'(m_read(int'(a)));
    e.i = (IRQ_BUILT != 0) && m_irqf && ((m_ctrl & 2) != 0);
    rd_q.push_back(e);
    address = a; rd_stb = 1'b1;
    cyc();
    rd_stb = 1'b0;
  endtask
  task automatic key();
    key_pulse = 1'b1;
    cyc();
    key_pulse = 1'b0;
    if (m_mode == 0) m_key = 1; else m_mode = (m_mode == 1) ? 2 : 1;
    cyc();
  endtask
  task automatic frame(input bit with_wr = 1'b0, input logic [31:0] d = 32'd0);
    vsync_n = 1'b0;
    if (with_wr) begin address = 2'd1; writedata = d; chipselect = 1'b1; write_n = 1'b0; end
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    if (with_wr) m_write(1, d);
    m_tick();
    cyc();
    checks++;
    if (pat_q.size() != 0) begin
      errors++;
      $display("FAIL frame_update: %0d expected pat_id change(s) missing one cycle after tick, pat_id=%0d", pat_q.size(), pat_id);
      pat_q.delete();
    end
    cyc();
    vsync_n = 1'b1;
    cyc(); cyc();
  endtask
  // monitor: checks every pat_id change and every read against the scoreboard queues
  always @(negedge clk) if (mon_en) begin
    if (int'(pat_id) != last_pat) begin
      checks++;
      if (pat_q.size() == 0) begin
        errors++;
        $display("FAIL pat_change: pat_id moved %0d -> %0d, no change expected", last_pat, pat_id);
      end else begin
        mon_e = pat_q.pop_front();
        if (int'(pat_id) != mon_e) begin
          errors++;
          $display("FAIL pat_change: pat_id=%0d expected %0d", pat_id, mon_e);
        end
      end
      last_pat = int'(pat_id);
    end
    if (rd_stb) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_queue: read with no expected entry");
      end else begin
        mon_r = rd_q.pop_front();
        if (readdata !== mon_r.d || irq !== mon_r.i) begin
          errors++;
          $display("FAIL read_reg%0d: readdata=%08h irq=%0b expected %08h irq=%0b", mon_r.a, readdata, irq, mon_r.d, mon_r.i);
        end
      end
    end
  end
  initial begin
    m_reset();
    cyc(); cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    mon_en = 1'b1;
    // reset values
    for (int a = 0; a < 4; a++) rd(2'(a));
    checks++;
    if (pat_id !== 2'd0 || irq !== 1'b0) begin errors++; $display("FAIL reset_out: pat_id=%0d irq=%0b expected 0 0", pat_id, irq); end
    // manual write held until frame boundary, then irq and W1C
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd2);
    rd(2'd3); rd(2'd1);
    frame();
    rd(2'd1); rd(2'd3);
    wr(2'd3, 32'd2);
    rd(2'd3);
    // auto increment with DWELL=3 from 3
    wr(2'd2, 32'd3);
    wr(2'd1, 32'd3);
    frame();
    wr(2'd0, 32'd1);
    for (int i = 0; i < 12; i++) frame();
    rd(2'd1);
    // auto decrement
    wr(2'd0, 32'd5);
    for (int i = 0; i < 12; i++) frame();
    rd(2'd1);
    // collision: CPU write at the tick that would step 2->3
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd2);
    frame(); frame(); frame();
    frame(1'b1, 32'd1);
    for (int i = 0; i < 3; i++) frame();
    rd(2'd1);
    // pause and resume
    key();
    for (int i = 0; i < 5; i++) frame();
    key();
    for (int i = 0; i < 4; i++) frame();
    // manual double key collapses to one step
    wr(2'd0, 32'd0);
    key(); key();
    frame();
    rd(2'd1);
    // invalid PAT and zero DWELL
    wr(2'd1, 32'd5);
    rd(2'd3);
    frame();
    wr(2'd3, 32'd4);
    rd(2'd3);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 4; i++) frame();
    rd(2'd1);
    // randomized operations
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: wr(2'd0, 32'($urandom_range(0, 7)));
        1: wr(2'd1, 32'($urandom_range(0, 5)));
        2: wr(2'd2, 32'($urandom_range(0, 3)));
        3: wr(2'd3, 32'($urandom_range(0, 7)));
        4: key();
        5, 6, 7: frame();
        8: rd(2'($urandom_range(0, 3)));
        default: frame(1'b1, 32'($urandom_range(0, 5)));
      endcase
    end
    for (int a = 0; a < 4; a++) rd(2'(a));
    // reset mid-frame drops the pending target
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd3);
    frame();
    wr(2'd1, 32'd1);
    vsync_n = 1'b0;
    cyc();
    reset_n = 1'b0;
    #1;
    checks++;
    if (pat_id !== 2'd0 || irq !== 1'b0) begin errors++; $display("FAIL async_reset: pat_id=%0d irq=%0b expected 0 0", pat_id, irq); end
    m_reset();
    vsync_n = 1'b1;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc(); cyc();
    for (int a = 0; a < 4; a++) rd(2'(a));
    frame();
    rd(2'd1);
    checks++;
    if (rd_q.size() != 0 || pat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d pat changes left over, expected 0", rd_q.size(), pat_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
